// File: rtl/fb_burst_reader.sv
// Framebuffer reader: fetches pixels with Wishbone incrementing bursts into a
// first-word-fall-through FIFO and streams them out with frame/line markers.
module fb_burst_reader #(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_sm,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic        wb_ack,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol
);

  localparam int NPIX = HDISP * VDISP;
  localparam int WW   = (NPIX  > 1) ? $clog2(NPIX)  : 1;
  localparam int XW   = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW   = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  localparam logic [WW-1:0] WLAST = WW'(NPIX - 1);
  localparam logic [XW-1:0] XLAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] YLAST = YW'(VDISP - 1);
  localparam logic [CW-1:0] ROOM_LIMIT = CW'(FIFO_DEPTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t         state_q, state_d;
  logic           cyc_q, cyc_d;
  logic [WW-1:0]  widx_q, widx_d;
  logic [31:0]    adr_q, adr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [XW-1:0]  px_q, px_d;
  logic [YW-1:0]  py_q, py_d;
  logic [31:0]    mem_q [FIFO_DEPTH];

  logic           push_s, pop_s, room_s, room_after_s;
  logic [2:0]     cti_s;

  assign pix_valid = (count_q != CW'(0));
  assign pix_data  = mem_q[rd_ptr_q];
  assign pix_sof   = pix_valid & (px_q == XW'(0)) & (py_q == YW'(0));
  assign pix_eol   = pix_valid & (px_q == XLAST);

  assign wb_cyc = cyc_q;
  assign wb_stb = cyc_q;
  assign wb_adr = adr_q;
  assign wb_cti = cti_s;
  assign wb_we  = 1'b0;
  assign wb_sel = 4'hF;
  assign wb_bte = 2'b00;

  // One slot stays free for the word in flight, so a push never finds the FIFO full.
  always_comb begin
    push_s       = cyc_q & wb_ack;
    pop_s        = pix_valid & pix_ready;
    count_d      = count_q + CW'(push_s) - CW'(pop_s);
    room_s       = (count_d < ROOM_LIMIT);
    room_after_s = ((count_q + CW'(1) - CW'(pop_s)) < ROOM_LIMIT);
    wr_ptr_d     = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d     = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
  end

  always_comb begin
    cti_s = 3'b000;
    if (state_q == READ) begin
      cti_s = (!enable || !room_after_s) ? 3'b111 : 3'b010;
    end else begin
      cti_s = 3'b000;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    widx_d  = widx_q;
    adr_d   = adr_q;
    case (state_q)
      IDLE: begin
        if (enable && room_s) begin
          state_d = READ;
          cyc_d   = 1'b1;
        end else begin
          state_d = IDLE;
          cyc_d   = 1'b0;
        end
      end
      READ: begin
        // The strobe is only released on an ack, never mid-word.
        if (wb_ack) begin
          widx_d = (widx_q == WLAST) ? WW'(0) : (widx_q + WW'(1));
          adr_d  = BASE_ADDR + (32'(widx_d) << 2);
          if (!enable || !room_s) begin
            state_d = IDLE;
            cyc_d   = 1'b0;
          end else begin
            state_d = READ;
            cyc_d   = 1'b1;
          end
        end else begin
          state_d = READ;
          cyc_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (pop_s) begin
      if (px_q == XLAST) begin
        px_d = XW'(0);
        py_d = (py_q == YLAST) ? YW'(0) : (py_q + YW'(1));
      end else begin
        px_d = px_q + XW'(1);
      end
    end else begin
      px_d = px_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cyc_q    <= 1'b0;
      widx_q   <= WW'(0);
      adr_q    <= BASE_ADDR;
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      px_q     <= XW'(0);
      py_q     <= YW'(0);
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      widx_q   <= widx_d;
      adr_q    <= adr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      px_q     <= px_d;
      py_q     <= py_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wb_dat_sm;
    end
  end

endmodule

// File: tb/tb_fb_burst_reader.sv
// Bench for fb_burst_reader: Wishbone slave model with a RAM image, a
// stream-level reference model, scenario table and multi-cycle corner cases.
module tb_fb_burst_reader;

  localparam int          HD    = 8;
  localparam int          VD    = 4;
  localparam int          NPIX  = HD * VD;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk, rst_n, enable;
  logic [31:0] wb_adr, wb_dat_sm, pix_data;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [3:0]  wb_sel;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic        pix_valid, pix_ready, pix_sof, pix_eol;

  fb_burst_reader #(.HDISP(HD), .VDISP(VD), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .wb_adr(wb_adr), .wb_dat_sm(wb_dat_sm), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte), .wb_ack(wb_ack),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  logic [31:0] ram [NPIX];
  int mcount, pop_idx, ack_idx, sof_seen;
  int pop_limit, ready_pct, slave_lat, exp_cti;
  logic prev_wait, prev_stop, push, pop;
  logic [31:0] prev_adr;

  // Wishbone slave: waits slave_lat cycles per word (negative = random 0..3).
  initial begin
    int wcnt, cur_lat;
    wb_ack = 1'b0; wb_dat_sm = 32'h0; wcnt = 0; cur_lat = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        wb_ack = 1'b0; wcnt = 0;
      end else begin
        if (wb_ack) begin
          wb_ack = 1'b0; wcnt = 0;
          cur_lat = (slave_lat < 0) ? int'($urandom_range(3)) : slave_lat;
        end
        if (wb_cyc && wb_stb) begin
          if (wcnt >= cur_lat) begin
            wb_ack = 1'b1;
            wb_dat_sm = ram[wb_adr[6:2]];
          end else begin
            wcnt++;
          end
        end else begin
          wcnt = 0;
          cur_lat = (slave_lat < 0) ? int'($urandom_range(3)) : slave_lat;
        end
      end
    end
  end

  // Consumer: random ready, stops accepting once pop_limit pixels were taken.
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      pix_ready = (pop_idx < pop_limit) && (int'($urandom_range(99)) < ready_pct);
    end
  end

  // Reference model: expected pixel k is ram[k mod NPIX]; fetch j reads word j mod NPIX.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mcount = 0; pop_idx = 0; ack_idx = 0; prev_wait = 1'b0; prev_stop = 1'b0;
      end else begin
        push = wb_cyc & wb_stb & wb_ack;
        pop  = pix_valid & pix_ready;
        check("valid", 32'(pix_valid), 32'(mcount != 0));
        if (prev_wait) begin
          check("stb_held", {30'h0, wb_cyc, wb_stb}, 32'h3);
          check("adr_held", wb_adr, prev_adr);
        end
        if (prev_stop) check("idle_when_disabled", 32'(wb_cyc), 32'h0);
        if (pop) begin
          check("data", pix_data, ram[pop_idx % NPIX]);
          check("sof", 32'(pix_sof), 32'((pop_idx % NPIX) == 0));
          check("eol", 32'(pix_eol), 32'((pop_idx % HD) == HD - 1));
          sof_seen += int'(pix_sof);
          pop_idx++;
        end
        if (push) begin
          check("adr", wb_adr, BASE + 32'(4 * (ack_idx % NPIX)));
          exp_cti = (!enable || (mcount + 1 - int'(pop) >= DEPTH - 1)) ? 7 : 2;
          check("cti", 32'(wb_cti), 32'(exp_cti));
          check("no_overflow", 32'(mcount < DEPTH), 32'h1);
          ack_idx++;
        end
        prev_wait = wb_cyc & wb_stb & ~wb_ack;
        prev_adr  = wb_adr;
        prev_stop = ~enable & (~wb_cyc | push);
        mcount    = mcount + int'(push) - int'(pop);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int lat;
    int rpct;
    int npops;
    int exp_sof;
  } scen_t;

  scen_t tbl [4];

  initial begin
    int n;
    tbl[0] = '{12, 100, 32, 1};
    tbl[1] = '{0,  50,  96, 3};
    tbl[2] = '{3,  30,  40, 2};
    tbl[3] = '{-1, 90,  70, 3};
    for (int i = 0; i < NPIX; i++) ram[i] = $urandom;
    rst_n = 1'b0; enable = 1'b0; ready_pct = 0; slave_lat = 0; pop_limit = 1 << 30;
    sof_seen = 0; mcount = 0; pop_idx = 0; ack_idx = 0;
    do_reset();

    @(negedge clk);
    check("rst_cyc", 32'(wb_cyc), 32'h0);
    check("rst_stb", 32'(wb_stb), 32'h0);
    check("rst_adr", wb_adr, BASE);
    check("rst_cti", 32'(wb_cti), 32'h0);
    check("rst_valid", 32'(pix_valid), 32'h0);
    check("tie_we_sel_bte", {25'h0, wb_we, wb_sel, wb_bte}, {25'h0, 1'b0, 4'hF, 2'b00});

    for (int s = 0; s < 4; s++) begin
      enable = 1'b0;
      do_reset();
      slave_lat = tbl[s].lat; ready_pct = tbl[s].rpct; pop_limit = tbl[s].npops;
      sof_seen = 0;
      @(posedge clk); #1 enable = 1'b1;
      @(negedge clk); check("first_stb_wait", 32'(wb_cyc), 32'h0);
      @(negedge clk); check("first_stb", {30'h0, wb_cyc, wb_stb}, 32'h3);
      n = 0;
      while (pop_idx < tbl[s].npops && n < 5000) begin @(posedge clk); n++; end
      check("scenario_timeout", 32'(pop_idx >= tbl[s].npops), 32'h1);
      check("sof_count", 32'(sof_seen), 32'(tbl[s].exp_sof));
      @(posedge clk); #1 enable = 1'b0;
      repeat (20) @(posedge clk);
    end

    // Consumer stalled: fill stops one short of full, then streams at full rate.
    do_reset();
    pop_limit = 1 << 30; slave_lat = 0; ready_pct = 0;
    @(posedge clk); #1 enable = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("fill_words", 32'(ack_idx), 32'(DEPTH - 1));
    check("fill_cyc_low", 32'(wb_cyc), 32'h0);
    ready_pct = 100;
    repeat (100) @(posedge clk);
    #1;
    check("stream_throughput", 32'(pop_idx >= 95), 32'h1);

    // Enable dropped in the middle of a slow word.
    enable = 1'b0;
    do_reset();
    slave_lat = 12; ready_pct = 100;
    @(posedge clk); #1 enable = 1'b1;
    n = 0;
    while (ack_idx < 3 && n < 200) begin @(posedge clk); n++; end
    check("drop_setup_timeout", 32'(ack_idx >= 3), 32'h1);
    repeat (4) @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    check("drop_stb_kept", 32'(wb_stb), 32'h1);
    check("drop_cti_end", 32'(wb_cti), 32'h7);
    n = 0;
    while (wb_cyc && n < 40) begin @(posedge clk); #1; n++; end
    check("drop_one_word", 32'(ack_idx), 32'h4);
    repeat (10) @(posedge clk);
    #1 enable = 1'b1;
    n = 0;
    while (ack_idx < 8 && n < 200) begin @(posedge clk); n++; end
    check("resume", 32'(ack_idx >= 8), 32'h1);

    // Reset in the middle of a burst.
    n = 0;
    while (!wb_cyc && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("async_rst_cyc_stb", {30'h0, wb_cyc, wb_stb}, 32'h0);
    check("async_rst_valid", 32'(pix_valid), 32'h0);
    slave_lat = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    n = 0;
    while (pop_idx < 4 && n < 200) begin @(posedge clk); n++; end
    check("after_rst_pops", 32'(pop_idx >= 4), 32'h1);

    enable = 1'b0;
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
